// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types, defaults and address helper for the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_CLEAR = 2'd1,
        RF_DONE  = 2'd2
    } rf_state_t;

    localparam int RF_XLEN_DEFAULT     = 32;
    localparam int RF_NUM_REGS_DEFAULT = 32;

    // True when an address names a real, writable register.
    function automatic logic rf_addr_ok(input int addr, input int num_regs, input bit zero_reg);
        return (addr < num_regs) && !(zero_reg && (addr == 0));
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clear_fsm.sv
// ============================================================================
// Module      : regfile_clear_fsm
// Description : Sequential clear engine; walks the file one register per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS_DEFAULT,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear_req,
    output logic              o_clr_en,
    output logic [ADDR_W-1:0] o_clr_idx,
    output logic              o_clear_busy,
    output logic              o_clear_done
);

    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS - 1);

    rf_state_t         r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_clear_busy;
    logic              r_clear_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RF_IDLE;
            r_idx        <= '0;
            r_clear_busy <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            case (r_state)
                RF_IDLE: begin
                    if (i_clear_req) begin
                        r_state      <= RF_CLEAR;
                        r_idx        <= '0;
                        r_clear_busy <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (r_idx == c_last_idx) begin
                        r_state      <= RF_DONE;
                        r_clear_done <= 1'b1;
                    end else begin
                        r_idx <= r_idx + ADDR_W'(1);
                    end
                end
                RF_DONE: begin
                    r_state      <= RF_IDLE;
                    r_clear_busy <= 1'b0;
                    r_clear_done <= 1'b0;
                end
                default: begin
                    r_state      <= RF_IDLE;
                    r_clear_busy <= 1'b0;
                    r_clear_done <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_en     = (r_state == RF_CLEAR);
    assign o_clr_idx    = r_idx;
    assign o_clear_busy = r_clear_busy;
    assign o_clear_done = r_clear_done;

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : RV32I integer register file, 2R/1W, with busy-bit scoreboard
//               and sequential clear. Optional macro REGFILE_BYPASS_EN
//               forwards same-cycle writes to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_DEFAULT,
    parameter int NUM_REGS = RF_NUM_REGS_DEFAULT,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] read_register_1,
    input  logic [ADDR_W-1:0] read_register_2,
    output logic [XLEN-1:0]   read_data_1,
    output logic [XLEN-1:0]   read_data_2,
    output logic              busy_1,
    output logic              busy_2,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [XLEN-1:0]   data_to_write,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done
);

    logic [XLEN-1:0]     r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;

    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_idx;
    logic              w_clear_busy;
    logic              w_clear_done;
    logic              w_idle;
    logic              w_wr_accept;
    logic              w_iss_accept;
    logic [XLEN-1:0]   w_rd1;
    logic [XLEN-1:0]   w_rd2;
    logic              w_b1;
    logic              w_b2;

    regfile_clear_fsm #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_clear_fsm (
        .clk          (clk_in),
        .rst_n        (reset_n),
        .i_clear_req  (clear_req),
        .o_clr_en     (w_clr_en),
        .o_clr_idx    (w_clr_idx),
        .o_clear_busy (w_clear_busy),
        .o_clear_done (w_clear_done)
    );

    // Decode and writeback are frozen for the whole clear, including DONE.
    assign w_idle       = !w_clear_busy;
    assign w_wr_accept  = w_idle && reg_write &&
                          rf_addr_ok(32'(write_register), NUM_REGS, ZERO_REG);
    assign w_iss_accept = w_idle && issue_valid &&
                          rf_addr_ok(32'(issue_rd), NUM_REGS, ZERO_REG);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_clr_en && (w_clr_idx == ADDR_W'(i))) begin
                    r_regs[i] <= '0;
                end else if (w_wr_accept && (write_register == ADDR_W'(i))) begin
                    r_regs[i] <= data_to_write;
                end
            end
        end
    end

    // Issue is checked before the write release so a new producer wins.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_clr_en && (w_clr_idx == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end else if (w_iss_accept && (issue_rd == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_accept && (write_register == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_b1  = 1'b0;
        if (rf_addr_ok(32'(read_register_1), NUM_REGS, ZERO_REG)) begin
            w_rd1 = r_regs[read_register_1];
            w_b1  = r_busy[read_register_1];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_accept && (write_register == read_register_1)) begin
            w_rd1 = data_to_write;
            w_b1  = 1'b0;
        end
`endif
    end

    always_comb begin
        w_rd2 = '0;
        w_b2  = 1'b0;
        if (rf_addr_ok(32'(read_register_2), NUM_REGS, ZERO_REG)) begin
            w_rd2 = r_regs[read_register_2];
            w_b2  = r_busy[read_register_2];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_accept && (write_register == read_register_2)) begin
            w_rd2 = data_to_write;
            w_b2  = 1'b0;
        end
`endif
    end

    assign read_data_1 = w_rd1;
    assign read_data_2 = w_rd2;
    assign busy_1      = w_b1;
    assign busy_2      = w_b2;
    assign clear_busy  = w_clear_busy;
    assign clear_done  = w_clear_done;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench for regfile_scoreboard (32x32 and 16x64).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rr1, rr2, wa, ird;
    logic [31:0] rd1, rd2, wd;
    logic        b1, b2, we, iv, creq, cbusy, cdone;

    logic [3:0]  d2_rr1, d2_rr2, d2_wa, d2_ird;
    logic [63:0] d2_rd1, d2_rd2, d2_wd;
    logic        d2_b1, d2_b2, d2_we, d2_iv, d2_creq, d2_cbusy, d2_cdone;

    regfile_scoreboard #(.XLEN(32), .NUM_REGS(32), .ZERO_REG(1'b1)) dut (
        .clk_in(clk), .reset_n(rst_n),
        .read_register_1(rr1), .read_register_2(rr2),
        .read_data_1(rd1), .read_data_2(rd2), .busy_1(b1), .busy_2(b2),
        .reg_write(we), .write_register(wa), .data_to_write(wd),
        .issue_valid(iv), .issue_rd(ird), .clear_req(creq),
        .clear_busy(cbusy), .clear_done(cdone)
    );

    regfile_scoreboard #(.XLEN(64), .NUM_REGS(16), .ZERO_REG(1'b1)) dut2 (
        .clk_in(clk), .reset_n(rst_n),
        .read_register_1(d2_rr1), .read_register_2(d2_rr2),
        .read_data_1(d2_rd1), .read_data_2(d2_rd2), .busy_1(d2_b1), .busy_2(d2_b2),
        .reg_write(d2_we), .write_register(d2_wa), .data_to_write(d2_wd),
        .issue_valid(d2_iv), .issue_rd(d2_ird), .clear_req(d2_creq),
        .clear_busy(d2_cbusy), .clear_done(d2_cdone)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: register contents, busy flags, and position within a clear
    // (-1 idle, 0..N-1 clearing that register, N the completion cycle).
    logic [31:0] m_reg  [N];
    logic        m_busy [N];
    int          m_pos = -1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_reg[i]  <= '0;
                m_busy[i] <= 1'b0;
            end
            m_pos <= -1;
        end else if (m_pos < 0) begin
            if (we && wa != 0) begin
                m_reg[wa]  <= wd;
                m_busy[wa] <= 1'b0;
            end
            if (iv && ird != 0) m_busy[ird] <= 1'b1;
            if (creq) m_pos <= 0;
        end else if (m_pos < N) begin
            m_reg[m_pos]  <= '0;
            m_busy[m_pos] <= 1'b0;
            m_pos <= m_pos + 1;
        end else begin
            m_pos <= -1;
        end
    end

    function automatic logic fwd(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        return (m_pos < 0) && we && (wa != 0) && (wa == a);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (fwd(a)) return wd;
        return (a == 0) ? 32'h0 : m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (fwd(a)) return 1'b0;
        return (a == 0) ? 1'b0 : m_busy[a];
    endfunction

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("rd1", 64'(rd1), 64'(exp_data(rr1)));
            check("rd2", 64'(rd2), 64'(exp_data(rr2)));
            check("busy1", 64'(b1), 64'(exp_busy(rr1)));
            check("busy2", 64'(b2), 64'(exp_busy(rr2)));
            check("clear_busy", 64'(cbusy), 64'(m_pos >= 0));
            check("clear_done", 64'(cdone), 64'(m_pos == N));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int nb, nd, dk;

    initial begin
        rst_n = 1'b0;
        {rr1, rr2, wa, ird, wd, we, iv, creq} = '0;
        {d2_rr1, d2_rr2, d2_wa, d2_ird, d2_wd, d2_we, d2_iv, d2_creq} = '0;
        rr1 = 5'd5;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd1", 64'(rd1), 64'h0);
        check("reset_clear_busy", 64'(cbusy), 64'h0);
        check("reset_clear_done", 64'(cdone), 64'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        cyc();

        // Basic write then read, x0 reads zero.
        we = 1; wa = 5; wd = 32'hDEADBEEF; rr1 = 5; rr2 = 0;
        cyc();
        we = 0; #1;
        check("x5_read", 64'(rd1), 64'hDEADBEEF);
        check("x0_read", 64'(rd2), 64'h0);
        check("model_x5", 64'(m_reg[5]), 64'hDEADBEEF);

        // Writes and issues to x0 are ignored.
        we = 1; wa = 0; wd = 32'h12345678; iv = 1; ird = 0; rr1 = 0;
        cyc();
        we = 0; iv = 0; #1;
        check("x0_after_write", 64'(rd1), 64'h0);
        check("x0_busy", 64'(b1), 64'h0);

        // Scoreboard set, release, and issue+write collision.
        iv = 1; ird = 7; rr1 = 7;
        cyc();
        iv = 0; #1;
        check("x7_busy_issue", 64'(b1), 64'h1);
        we = 1; wa = 7; wd = 32'h77;
        cyc();
        we = 0; #1;
        check("x7_busy_release", 64'(b1), 64'h0);
        iv = 1; ird = 7; we = 1; wa = 7; wd = 32'h78;
        cyc();
        iv = 0; we = 0; #1;
        check("x7_busy_collision", 64'(b1), 64'h1);
        check("model_busy7", 64'(m_busy[7]), 64'h1);

        // Same-cycle read of a register being written.
        we = 1; wa = 3; wd = 32'hA5A5A5A5; rr1 = 3; #1;
`ifdef REGFILE_BYPASS_EN
        check("x3_same_cycle", 64'(rd1), 64'hA5A5A5A5);
`else
        check("x3_same_cycle", 64'(rd1), 64'h0);
`endif
        cyc();
        we = 0; #1;
        check("x3_next_cycle", 64'(rd1), 64'hA5A5A5A5);

        // Randomised traffic with occasional clears.
        for (int c = 0; c < 800; c++) begin
            we   = $urandom_range(0, 1) == 1;
            wa   = 5'($urandom);
            wd   = $urandom;
            iv   = $urandom_range(0, 2) == 0;
            ird  = 5'($urandom);
            rr1  = 5'($urandom);
            rr2  = 5'($urandom);
            creq = $urandom_range(0, 59) == 0;
            cyc();
        end
        {we, iv, creq} = '0;
        for (int c = 0; c < 40 && cbusy; c++) cyc();
        check("idle_after_random", 64'(cbusy), 64'h0);

        // Fill, clear, and verify clear timing and dropped write.
        for (int i = 1; i < N; i++) begin
            we = 1; wa = 5'(i); wd = 32'(i);
            cyc();
        end
        we = 0; creq = 1;
        cyc();
        creq = 0;
        nb = 0; nd = 0; dk = 0;
        for (int k = 1; k <= 40; k++) begin
            if (cbusy) nb++;
            if (cdone) begin nd++; dk = k; end
            we = (k == 5); wa = 4; wd = 32'hFFFF0000; rr1 = 4;
            cyc();
        end
        we = 0;
        check("clear_busy_cycles", 64'(nb), 64'd33);
        check("clear_done_pulses", 64'(nd), 64'd1);
        check("clear_done_cycle", 64'(dk), 64'd33);
        for (int i = 0; i < N; i++) begin
            rr1 = 5'(i); #1;
            check("after_clear", 64'(rd1), 64'h0);
        end

        // Reset in the middle of a clear.
        for (int i = 1; i < N; i++) begin
            we = 1; wa = 5'(i); wd = 32'(i * 3 + 1);
            cyc();
        end
        we = 0; iv = 1; ird = 25;
        cyc();
        iv = 0; creq = 1;
        cyc();
        creq = 0; rr1 = 20; rr2 = 25;
        repeat (10) cyc();
        check("mid_clear_x20", 64'(rd1), 64'd61);
        rst_n = 0; #1;
        check("abort_clear_busy", 64'(cbusy), 64'h0);
        check("abort_clear_done", 64'(cdone), 64'h0);
        check("abort_rd1", 64'(rd1), 64'h0);
        check("abort_busy2", 64'(b2), 64'h0);
        repeat (2) cyc();
        rst_n = 1;
        nd = 0;
        for (int k = 0; k < 40; k++) begin
            if (cdone || cbusy) nd++;
            cyc();
        end
        check("no_done_after_abort", 64'(nd), 64'h0);

        // 16 x 64 configuration.
        d2_we = 1; d2_wa = 4'd15; d2_wd = 64'h0123456789ABCDEF; d2_rr1 = 4'd15;
        cyc();
        d2_we = 0; #1;
        check("w64_x15", d2_rd1, 64'h0123456789ABCDEF);
        d2_creq = 1;
        cyc();
        d2_creq = 0;
        nb = 0; nd = 0; dk = 0;
        for (int k = 1; k <= 25; k++) begin
            if (d2_cbusy) nb++;
            if (d2_cdone) begin nd++; dk = k; end
            cyc();
        end
        check("w64_clear_cycles", 64'(nb), 64'd17);
        check("w64_done_cycle", 64'(dk), 64'd17);
        check("w64_done_pulses", 64'(nd), 64'd1);
        check("w64_x15_cleared", d2_rd1, 64'h0);

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
